fetch_unit: RTL and testbench

Instruction fetch stage that sits directly upstream of the instruction decoder. It owns the PC and issues in-order requests to instruction memory over a valid/ready channel. Returned words are buffered in a small prefetch queue, and the head is presented to the decoder as a 32-bit instruction plus a stall/bubble flag. It handles back-pressure from the hazard unit and PC redirects from branch/jump resolution, including discarding responses that are already in flight.

---
 rtl/cpu_pkg.sv | 21 ++
 rtl/fetch_queue.sv | 66 ++++++
 rtl/fetch_unit.sv | 134 +++++++++++++
 tb/tb_fetch_unit.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared widths, NOP encoding, fetch entry type and fetch FSM states
package cpu_pkg;

    localparam int XLEN   = 32;
    localparam int INSN_W = 32;

    // addi x0, x0, 0
    localparam logic [INSN_W-1:0] NOP_INSN = 32'h0000_0013;

    typedef struct packed {
        logic [INSN_W-1:0] insn;
        logic [XLEN-1:0]   pc;
    } fetch_entry_t;

    // RUN: no stale responses outstanding; DRAIN: stale responses still being dropped
    typedef enum logic {
        FETCH_RUN   = 1'b0,
        FETCH_DRAIN = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - synchronous FIFO of fetch entries with push, pop, flush and occupancy
module fetch_queue
    import cpu_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   flush,
    input  logic                   push,
    input  fetch_entry_t           din,
    input  logic                   pop,
    output fetch_entry_t           dout,
    output logic [$clog2(DEPTH):0] count,
    output logic                   empty,
    output logic                   full
);

    localparam int AW = $clog2(DEPTH);

    fetch_entry_t      mem [DEPTH];
    logic [AW-1:0]     rd_ptr;
    logic [AW-1:0]     wr_ptr;
    logic [AW:0]       cnt;
    logic              do_push;
    logic              do_pop;

    assign empty   = (cnt == '0);
    assign full    = (cnt == (AW+1)'(DEPTH));
    assign count   = cnt;
    assign dout    = mem[rd_ptr];
    // A full queue may still accept a push when the head leaves on the same edge.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // Storage array; contents are don't-care once flushed, so it needs no reset.
    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointer and occupancy bookkeeping; flush empties the queue in one edge.
    always_ff @(posedge clk) begin
        if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + (AW+1)'(1);
                2'b01:   cnt <= cnt - (AW+1)'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    a_no_overflow:  assert property (@(posedge clk) disable iff (flush) !(push && full && !pop));
    a_no_underflow: assert property (@(posedge clk) disable iff (flush) !(pop && empty));

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage with prefetch queue, redirect flush and stale-response drop
// Optional: define FETCH_PERF_EN to add perf_fetched / perf_bubbles counters.
module fetch_unit
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          QDEPTH   = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        hold,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic        bubble
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_bubbles
`endif
);

    localparam int          CW      = $clog2(QDEPTH) + 1;
    localparam logic [CW:0] CREDITS = (CW+1)'(QDEPTH);

    logic [31:0]   pc;
    logic [CW-1:0] inflight;
    logic [CW-1:0] drop;
    logic [CW-1:0] inflight_next;
    logic [CW-1:0] drop_next;
    fetch_state_t  state;

    fetch_entry_t  q_din, q_head, t_din, t_head;
    logic [CW-1:0] q_count, t_count;
    logic          q_empty, q_full, t_empty, t_full;
    logic          accept, rsp_take, discard, q_push, q_pop, q_flush;
    logic          unused_sigs;

    // Credits cover both outstanding requests and buffered words, so the queue cannot overflow.
    assign imem_req_valid = !rst && !redirect_valid &&
                            (({1'b0, inflight} + {1'b0, q_count}) < CREDITS);
    assign imem_req_addr  = pc;
    assign accept         = imem_req_valid && imem_req_ready;
    assign rsp_take       = imem_rsp_valid && !t_empty;
    assign discard        = rsp_take && (state == FETCH_DRAIN);
    assign q_push         = rsp_take && !discard && !redirect_valid && !rst;
    assign q_flush        = rst || redirect_valid;
    assign bubble         = rst || redirect_valid || q_empty;
    assign q_pop          = !bubble && !hold;
    assign instr          = bubble ? '0 : q_head.insn;
    assign instr_pc       = bubble ? '0 : q_head.pc;

    assign t_din  = '{insn: '0, pc: pc};
    assign q_din  = '{insn: imem_rsp_data, pc: t_head.pc};
    assign unused_sigs = ^{t_head.insn, t_count, t_full, q_full, redirect_pc[1:0]};

    // Request-PC FIFO: tags each response with the address it was fetched from.
    fetch_queue #(.DEPTH(QDEPTH)) u_tag_fifo (
        .clk   (clk),
        .flush (rst),
        .push  (accept),
        .din   (t_din),
        .pop   (rsp_take),
        .dout  (t_head),
        .count (t_count),
        .empty (t_empty),
        .full  (t_full)
    );

    // Prefetch queue feeding the decoder.
    fetch_queue #(.DEPTH(QDEPTH)) u_prefetch_q (
        .clk   (clk),
        .flush (q_flush),
        .push  (q_push),
        .din   (q_din),
        .pop   (q_pop),
        .dout  (q_head),
        .count (q_count),
        .empty (q_empty),
        .full  (q_full)
    );

    // Next in-flight and drop counts; a redirect turns every remaining in-flight request stale.
    always_comb begin
        inflight_next = inflight + CW'(accept) - CW'(rsp_take);
        drop_next     = drop - CW'(discard);
        if (redirect_valid) begin
            drop_next = inflight - CW'(rsp_take);
        end
    end

    // PC, credit counters and RUN/DRAIN state.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc       <= RESET_PC;
            inflight <= '0;
            drop     <= '0;
            state    <= FETCH_RUN;
        end else begin
            inflight <= inflight_next;
            drop     <= drop_next;
            state    <= (drop_next != '0) ? FETCH_DRAIN : FETCH_RUN;
            if (redirect_valid) begin
                pc <= {redirect_pc[31:2], 2'b00};
            end else if (accept) begin
                pc <= pc + 32'd4;
            end
        end
    end

`ifdef FETCH_PERF_EN
    // Performance counters: queue pushes and unstalled bubble cycles, wrapping on overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_fetched <= '0;
            perf_bubbles <= '0;
        end else begin
            if (q_push) begin
                perf_fetched <= perf_fetched + 32'd1;
            end
            if (bubble && !hold) begin
                perf_bubbles <= perf_bubbles + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - self-checking bench for fetch_unit with memory model and stream reference model
module tb_fetch_unit;

    localparam int          QD  = 4;
    localparam logic [31:0] RPC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = 32'h0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        hold = 1'b0;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        bubble;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_bubbles;
`endif

    fetch_unit #(.RESET_PC(RPC), .QDEPTH(QD)) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .hold           (hold),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .bubble         (bubble)
`ifdef FETCH_PERF_EN
        ,
        .perf_fetched   (perf_fetched),
        .perf_bubbles   (perf_bubbles)
`endif
    );

    always #5 clk = ~clk;

    // Outstanding memory request: address the DUT sent, address the stream expects, stream generation, due cycle.
    typedef struct {
        logic [31:0] daddr;
        logic [31:0] eaddr;
        int          sgen;
        int          due;
    } mreq_t;

    typedef struct {
        logic        r;
        logic        h;
        logic        rd;
        logic        rdy;
        logic [31:0] rp;
        logic        e_bub;
        logic [31:0] e_pc;
        logic        e_rv;
        logic [31:0] e_addr;
    } vec_t;

    mreq_t       memq [$];
    logic [31:0] fq [$];
    vec_t        tbl [$];
    logic [31:0] req_pc = RPC;
    int          sgen = 0;
    int          cyc = 0;
    int          lat = 1;
    int          total = 0;
    int          bad = 0;
    logic        s_rv, s_bub;
    logic [31:0] s_addr, s_pc, s_instr;
    logic [31:0] m_pf = 32'h0;
    logic [31:0] m_pb = 32'h0;
    logic [31:0] s_pf = 32'h0;
    logic [31:0] s_pb = 32'h0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h0050_0093;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, act, exp);
        end
    endtask

    task automatic add_vec(input logic r, input logic h, input logic e_bub, input logic [31:0] e_pc,
                           input logic e_rv, input logic [31:0] e_addr);
        vec_t v;
        v.r = r; v.h = h; v.rd = 1'b0; v.rdy = 1'b1; v.rp = 32'h0;
        v.e_bub = e_bub; v.e_pc = e_pc; v.e_rv = e_rv; v.e_addr = e_addr;
        tbl.push_back(v);
    endtask

    // One clock window: drive after the edge, sample and check mid-cycle, advance the model for the next edge.
    task automatic cycle(input logic r, input logic h, input logic rd, input logic [31:0] rp, input logic rdy);
        logic        rsp_now, exp_rv, exp_bub;
        int          occ;
        mreq_t       m;
        logic [31:0] pop_unused;
        rsp_now = !r && (memq.size() > 0) && (memq[0].due <= cyc);
        rst = r; hold = h; redirect_valid = rd; redirect_pc = rp; imem_req_ready = rdy;
        imem_rsp_valid = rsp_now;
        imem_rsp_data  = rsp_now ? mem_word(memq[0].daddr) : $urandom();
        @(negedge clk);
        s_rv = imem_req_valid; s_addr = imem_req_addr; s_bub = bubble; s_pc = instr_pc; s_instr = instr;
`ifdef FETCH_PERF_EN
        s_pf = perf_fetched; s_pb = perf_bubbles;
`endif
        occ     = memq.size() + fq.size();
        exp_rv  = !r && !rd && (occ < QD);
        exp_bub = r || rd || (fq.size() == 0);
        chk("req_valid", 32'(s_rv), 32'(exp_rv));
        if (exp_rv) chk("req_addr", s_addr, req_pc);
        chk("bubble", 32'(s_bub), 32'(exp_bub));
        if (!exp_bub) begin
            chk("instr_pc", s_pc, fq[0]);
            chk("instr", s_instr, mem_word(fq[0]));
        end else if (!r && !rd) begin
            chk("instr_empty", s_instr, 32'h0);
        end
`ifdef FETCH_PERF_EN
        chk("perf_fetched", s_pf, m_pf);
        chk("perf_bubbles", s_pb, m_pb);
`endif
        if (r) begin
            memq.delete(); fq.delete(); req_pc = RPC; sgen++; m_pf = 32'h0; m_pb = 32'h0;
        end else begin
            if (exp_bub && !h) m_pb = m_pb + 32'd1;
            if (rd) begin
                if (rsp_now) m = memq.pop_front();
                fq.delete();
                sgen++;
                req_pc = {rp[31:2], 2'b00};
            end else begin
                if (!exp_bub && !h) pop_unused = fq.pop_front();
                if (rsp_now) begin
                    m = memq.pop_front();
                    if (m.sgen == sgen) begin
                        fq.push_back(m.eaddr);
                        m_pf = m_pf + 32'd1;
                    end
                end
                if (exp_rv && rdy) begin
                    m.daddr = s_addr; m.eaddr = req_pc; m.sgen = sgen; m.due = cyc + lat;
                    memq.push_back(m);
                    req_pc = req_pc + 32'd4;
                end
            end
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] got [4];
        logic [31:0] wexp [4];
        int          n;
        logic        found;
        wexp[0] = 32'hFFFF_FFF8; wexp[1] = 32'hFFFF_FFFC; wexp[2] = 32'h0000_0000; wexp[3] = 32'h0000_0004;

        // reset, streaming at latency 1, then hold until the queue is full
        add_vec(1'b1, 1'b0, 1'b1, 32'h0,  1'b0, 32'h0);
        add_vec(1'b1, 1'b0, 1'b1, 32'h0,  1'b0, 32'h0);
        add_vec(1'b0, 1'b0, 1'b1, 32'h0,  1'b1, 32'h0);
        add_vec(1'b0, 1'b0, 1'b1, 32'h0,  1'b1, 32'h4);
        add_vec(1'b0, 1'b0, 1'b0, 32'h0,  1'b1, 32'h8);
        add_vec(1'b0, 1'b0, 1'b0, 32'h4,  1'b1, 32'hC);
        add_vec(1'b0, 1'b0, 1'b0, 32'h8,  1'b1, 32'h10);
        add_vec(1'b0, 1'b1, 1'b0, 32'hC,  1'b1, 32'h14);
        add_vec(1'b0, 1'b1, 1'b0, 32'hC,  1'b1, 32'h18);
        for (int i = 0; i < 5; i++) add_vec(1'b0, 1'b1, 1'b0, 32'hC, 1'b0, 32'h0);
        add_vec(1'b0, 1'b0, 1'b0, 32'hC,  1'b0, 32'h0);
        add_vec(1'b0, 1'b0, 1'b0, 32'h10, 1'b1, 32'h1C);
        add_vec(1'b0, 1'b0, 1'b0, 32'h14, 1'b1, 32'h20);
        add_vec(1'b0, 1'b0, 1'b0, 32'h18, 1'b1, 32'h24);

        @(posedge clk);
        #1;
        lat = 1;
        foreach (tbl[i]) begin
            cycle(tbl[i].r, tbl[i].h, tbl[i].rd, tbl[i].rp, tbl[i].rdy);
            chk("tbl_bubble", 32'(s_bub), 32'(tbl[i].e_bub));
            if (!tbl[i].e_bub) begin
                chk("tbl_pc", s_pc, tbl[i].e_pc);
                chk("tbl_instr", s_instr, mem_word(tbl[i].e_pc));
            end
            chk("tbl_req_valid", 32'(s_rv), 32'(tbl[i].e_rv));
            if (tbl[i].e_rv) chk("tbl_req_addr", s_addr, tbl[i].e_addr);
        end

        // redirect to 0x103 with at least two requests in flight
        lat = 3;
        for (int k = 0; k < 20 && memq.size() < 2; k++) cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        chk("inflight_setup", 32'(memq.size() >= 2), 32'd1);
        cycle(1'b0, 1'b0, 1'b1, 32'h0000_0103, 1'b1);
        chk("redir_bubble", 32'(s_bub), 32'd1);
        cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        chk("redir_next_valid", 32'(s_rv), 32'd1);
        chk("redir_next_addr", s_addr, 32'h0000_0100);
        for (int k = 0; k < 30 && s_bub; k++) cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        chk("redir_first_seen", 32'(!s_bub), 32'd1);
        chk("redir_first_pc", s_pc, 32'h0000_0100);

        // redirect in the same cycle as a response
        lat = 2;
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            if (memq.size() > 0 && memq[0].due <= cyc) begin
                found = 1'b1;
                cycle(1'b0, 1'b0, 1'b1, 32'h0000_0200, 1'b1);
                chk("redir_rsp_bubble", 32'(s_bub), 32'd1);
            end else begin
                cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
            end
        end
        chk("redir_rsp_found", 32'(found), 32'd1);
        cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        for (int k = 0; k < 30 && s_bub; k++) cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        chk("redir_rsp_first_pc", s_pc, 32'h0000_0200);

        // PC wrap across 2^32
        lat = 1;
        cycle(1'b0, 1'b0, 1'b1, 32'hFFFF_FFF9, 1'b1);
        n = 0;
        for (int k = 0; k < 30 && n < 4; k++) begin
            cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
            if (!s_bub) begin
                got[n] = s_pc;
                n++;
            end
        end
        chk("wrap_count", n, 4);
        for (int i = 0; i < n; i++) chk("wrap_pc", got[i], wexp[i]);

        // reset mid-stream with a redirect pending
        cycle(1'b1, 1'b0, 1'b1, 32'h0000_0300, 1'b1);
        cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        chk("rst_bubble", 32'(s_bub), 32'd1);
        chk("rst_valid", 32'(s_rv), 32'd1);
        chk("rst_pc", s_addr, RPC);
`ifdef FETCH_PERF_EN
        chk("rst_perf_fetched", s_pf, 32'h0);
        chk("rst_perf_bubbles", s_pb, 32'h0);
`endif

        // randomized ready, latency, hold and redirects
        for (int k = 0; k < 10000; k++) begin
            logic        h, rd, rdy;
            logic [31:0] rp;
            lat = $urandom_range(1, 4);
            h   = ($urandom_range(0, 3) == 0);
            rd  = ($urandom_range(0, 39) == 0);
            rdy = ($urandom_range(0, 3) != 0);
            rp  = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom();
            cycle(1'b0, h, rd, rp, rdy);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
